// File: rtl/axi4_burst_split_pkg.sv
// Shared AXI4 encodings and constants for the burst splitter and its
// combinational burst-length calculator.
package axi4_burst_split_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
  localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
  localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
  localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI_SIZE_128B = 3'd7;

  localparam int AXI_4K_BITS       = 12;
  localparam int AXI_MAX_BURST_LEN = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } split_state_e;

  // Beats wider than 64 bits are not supported by the downstream fabric.
  function automatic logic size_supported(input logic [2:0] size);
    return size <= AXI_SIZE_8B;
  endfunction

endpackage

// File: rtl/axi4_burst_calc.sv
// Combinational burst sizing: largest INCR burst that fits the remaining
// beats, the configured maximum and the distance to the next 4 KB boundary.
module axi4_burst_calc
  import axi4_burst_split_pkg::*;
#(
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [AXI_4K_BITS-1:0] i_addr,
  input  logic [2:0]             i_size,
  input  logic [LEN_WIDTH-1:0]   i_remaining,
  output logic [8:0]             o_beats,
  output logic [7:0]             o_len
);

  localparam logic [AXI_4K_BITS:0] BOUNDARY = (AXI_4K_BITS + 1)'(1) << AXI_4K_BITS;
  localparam logic [AXI_4K_BITS:0] MAX_LEN  = (AXI_4K_BITS + 1)'(MAX_BURST_LEN);

  logic [AXI_4K_BITS:0] w_span;
  logic [AXI_4K_BITS:0] w_to4k;
  logic [AXI_4K_BITS:0] w_lim;

  // The address is size-aligned, so w_to4k is always at least one beat.
  assign w_span  = BOUNDARY - {1'b0, i_addr};
  assign w_to4k  = w_span >> i_size;
  assign w_lim   = (w_to4k < MAX_LEN) ? w_to4k : MAX_LEN;
  assign o_beats = (32'(i_remaining) < 32'(w_lim)) ? 9'(i_remaining) : 9'(w_lim);
  assign o_len   = 8'(o_beats - 9'd1);

endmodule

// File: rtl/axi4_burst_split.sv
// Initiator-side AXI4 address command generator: splits a linear request
// into INCR bursts that respect MAX_BURST_LEN and 4 KB boundaries.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready_o high
// CALC    | sizing the next burst from current address and remaining beats
// ISSUE   | burst presented on the address channel until accepted
module axi4_burst_split
  import axi4_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = AXI_MAX_BURST_LEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic [2:0]            req_size_i,
  output logic                  ax_valid_o,
  input  logic                  ax_ready_i,
  output logic [ADDR_WIDTH-1:0] ax_addr_o,
  output logic [7:0]            ax_len_o,
  output logic [2:0]            ax_size_o,
  output logic [1:0]            ax_burst_o,
  output logic                  done_o,
  output logic                  err_o
);

  split_state_e r_state;
  split_state_e w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [2:0]            r_size;
  logic [8:0]            r_beats;

  logic                  r_ax_valid;
  logic [ADDR_WIDTH-1:0] r_ax_addr;
  logic [7:0]            r_ax_len;
  logic [2:0]            r_ax_size;
  logic                  r_done;
  logic                  r_err;

  logic                  w_req_hs;
  logic                  w_ax_hs;
  logic                  w_size_ok;
  logic                  w_len_zero;
  logic                  w_last;
  logic [8:0]            w_calc_beats;
  logic [7:0]            w_calc_len;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_req_addr_aligned;

  axi4_burst_calc #(
    .LEN_WIDTH    (LEN_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_calc (
    .i_addr     (r_addr[AXI_4K_BITS-1:0]),
    .i_size     (r_size),
    .i_remaining(r_remaining),
    .o_beats    (w_calc_beats),
    .o_len      (w_calc_len)
  );

  assign req_ready_o = (r_state == S_IDLE) && !rst_i;
  assign w_req_hs    = req_valid_i && req_ready_o;
  assign w_ax_hs     = r_ax_valid && ax_ready_i;
  assign w_size_ok   = size_supported(req_size_i);
  assign w_len_zero  = (req_len_i == '0);
  assign w_last      = (r_remaining == LEN_WIDTH'(r_beats));
  assign w_step      = ADDR_WIDTH'(r_beats) << r_size;

  // Low address bits below the beat size are dropped so every burst is aligned.
  assign w_req_addr_aligned = req_addr_i & ({ADDR_WIDTH{1'b1}} << req_size_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_hs && w_size_ok && !w_len_zero) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_ax_hs) begin
          w_next = w_last ? S_IDLE : S_CALC;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_size      <= '0;
      r_beats     <= '0;
      r_ax_valid  <= 1'b0;
      r_ax_addr   <= '0;
      r_ax_len    <= '0;
      r_ax_size   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            if (!w_size_ok) begin
              r_err <= 1'b1;
            end else if (w_len_zero) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= w_req_addr_aligned;
              r_remaining <= req_len_i;
              r_size      <= req_size_i;
            end
          end
        end
        S_CALC: begin
          r_ax_addr  <= r_addr;
          r_ax_len   <= w_calc_len;
          r_ax_size  <= r_size;
          r_beats    <= w_calc_beats;
          r_ax_valid <= 1'b1;
        end
        S_ISSUE: begin
          // Dropping valid here leaves one idle cycle between bursts.
          if (w_ax_hs) begin
            r_ax_valid  <= 1'b0;
            r_addr      <= r_addr + w_step;
            r_remaining <= r_remaining - LEN_WIDTH'(r_beats);
            r_done      <= w_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ax_valid_o = r_ax_valid;
  assign ax_addr_o  = r_ax_addr;
  assign ax_len_o   = r_ax_len;
  assign ax_size_o  = r_ax_size;
  assign ax_burst_o = AXI_BURST_INCR;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_axi4_burst_split.sv
// Scoreboard bench for axi4_burst_split: a loop-based reference model queues
// the expected bursts and completion events, a negedge monitor checks them.
module tb_axi4_burst_split;
  import axi4_burst_split_pkg::*;

  localparam int AW  = 32;
  localparam int LW  = 16;
  localparam int MBL = 256;

  localparam int K_BURST = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [2:0]    req_size_i = '0;
  logic          ax_valid_o;
  logic          ax_ready_i = 1'b1;
  logic [AW-1:0] ax_addr_o;
  logic [7:0]    ax_len_o;
  logic [2:0]    ax_size_o;
  logic [1:0]    ax_burst_o;
  logic          done_o;
  logic          err_o;

  axi4_burst_split #(
    .ADDR_WIDTH   (AW),
    .LEN_WIDTH    (LW),
    .MAX_BURST_LEN(MBL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_len_i  (req_len_i),
    .req_size_i (req_size_i),
    .ax_valid_o (ax_valid_o),
    .ax_ready_i (ax_ready_i),
    .ax_addr_o  (ax_addr_o),
    .ax_len_o   (ax_len_o),
    .ax_size_o  (ax_size_o),
    .ax_burst_o (ax_burst_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   force_low = 0;
  int   rand_mode = 0;
  int   stall_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: walk the request beat range, cutting at 4 KB and MBL.
  function automatic void model(input logic [31:0] addr, input int len, input int size);
    logic [31:0] a;
    int          rem;
    int          to4k;
    int          b;
    exp_t        e;
    if (size > 3) begin
      e = '{K_ERR, 32'd0, 8'd0, 3'd0};
      exp_q.push_back(e);
      return;
    end
    a   = addr & ~((32'd1 << size) - 32'd1);
    rem = len;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / (1 << size);
      b = rem;
      if (b > MBL)  b = MBL;
      if (b > to4k) b = to4k;
      e = '{K_BURST, a, 8'(b - 1), 3'(size)};
      exp_q.push_back(e);
      a   = a + 32'(b * (1 << size));
      rem = rem - b;
    end
    e = '{K_DONE, 32'd0, 8'd0, 3'd0};
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) begin
    #1;
    if (force_low > 0) begin
      ax_ready_i = 1'b0;
      force_low--;
    end else if (rand_mode != 0) begin
      ax_ready_i = 1'($urandom % 2);
    end else begin
      ax_ready_i = 1'b1;
    end
  end

  logic        hold_v = 1'b0;
  logic [31:0] h_addr;
  logic [7:0]  h_len;
  logic [2:0]  h_size;
  logic        fin_due = 1'b0;
  logic        bubble_due = 1'b0;
  logic        req_pend = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst_i) begin
      hold_v     = 1'b0;
      fin_due    = 1'b0;
      bubble_due = 1'b0;
      req_pend   = 1'b0;
    end else begin
      if (fin_due) begin
        check("done_after_last_burst", done_o, 1'b1);
        fin_due = 1'b0;
      end
      if (bubble_due) begin
        check("bubble_after_burst", ax_valid_o, 1'b0);
        bubble_due = 1'b0;
      end
      if (req_pend && exp_q.size() > 0 && exp_q[0].kind != K_BURST)
        check("immediate_fin_latency", {done_o, err_o}, (exp_q[0].kind == K_DONE) ? 2'b10 : 2'b01);
      req_pend = req_valid_i && req_ready_o;

      if (done_o || err_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fin", {done_o, err_o}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("fin_kind", done_o ? K_DONE : K_ERR, mon_e.kind);
        end
      end

      if (hold_v && !ax_valid_o) check("valid_held", ax_valid_o, 1'b1);

      if (ax_valid_o) begin
        check("burst_type", ax_burst_o, AXI_BURST_INCR);
        if (hold_v) begin
          check("addr_stable", ax_addr_o, h_addr);
          check("len_stable", ax_len_o, h_len);
          check("size_stable", ax_size_o, h_size);
        end
        if (ax_ready_i) begin
          hold_v     = 1'b0;
          bubble_due = 1'b1;
          if (exp_q.size() == 0 || exp_q[0].kind != K_BURST) begin
            check("unexpected_burst", (exp_q.size() == 0) ? 99 : exp_q[0].kind, K_BURST);
          end else begin
            mon_e = exp_q.pop_front();
            check("burst_addr", ax_addr_o, mon_e.addr);
            check("burst_len", ax_len_o, mon_e.len);
            check("burst_size", ax_size_o, mon_e.size);
            if (exp_q.size() > 0 && exp_q[0].kind == K_DONE) fin_due = 1'b1;
          end
        end else begin
          hold_v = 1'b1;
          h_addr = ax_addr_o;
          h_len  = ax_len_o;
          h_size = ax_size_o;
          stall_cycles++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input int len, input int size, input bit chk_lat);
    int n;
    n = 0;
    while (!req_ready_o && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check("req_ready_timeout", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_len_i   = LW'(len);
    req_size_i  = 3'(size);
    @(posedge clk);
    model(a, len, size);
    #1;
    req_valid_i = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      check("latency_calc_cycle", ax_valid_o, 1'b0);
      @(negedge clk);
      check("latency_valid_plus2", ax_valid_o, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready_o) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) begin
      check("idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    int          rl;
    int          rs;
    int          n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready_o, 1'b0);
    check("rst_ax_valid", ax_valid_o, 1'b0);
    check("rst_ax_addr", ax_addr_o, 32'd0);
    check("rst_ax_len", ax_len_o, 8'd0);
    check("rst_ax_size", ax_size_o, 3'd0);
    check("rst_ax_burst", ax_burst_o, AXI_BURST_INCR);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready_o, 1'b1);
    @(posedge clk);
    #1;

    send(32'h0000_0000, 16, 2, 1'b1);
    wait_idle();
    send(32'h0000_0FF0, 16, 2, 1'b1);
    wait_idle();
    send(32'h0000_0000, 600, 0, 1'b1);
    wait_idle();

    stall_cycles = 0;
    force_low = 9;
    send(32'h0000_2000, 8, 3, 1'b0);
    wait_idle();
    check("backpressure_stall_ge5", stall_cycles >= 5, 1'b1);

    send(32'h0000_0040, 0, 2, 1'b0);
    wait_idle();
    send(32'h0000_0100, 4, 4, 1'b0);
    wait_idle();
    send(32'h0000_0003, 4, 2, 1'b1);
    wait_idle();

    force_low = 30;
    send(32'h0000_0100, 32, 2, 1'b0);
    n = 0;
    while (!ax_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_issue", ax_valid_o, 1'b1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    force_low = 0;
    @(negedge clk);
    check("post_rst_ax_valid", ax_valid_o, 1'b0);
    check("post_rst_req_ready", req_ready_o, 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(32'h0000_0100, 32, 2, 1'b1);
    wait_idle();

    rand_mode = 1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 63));
      rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700);
      rs = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      send(ra, rl, rs, 1'b0);
      wait_idle();
    end
    rand_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
